cipher_stream_feeder: RTL and testbench
=======================================

Name: cipher_stream_feeder

Overview:
- Upstream companion of the 128-bit encrypt core. It accepts a 32-bit input word stream carrying plaintext then key, and drives the core's Avalon-MM slave port as a master: 8 writes, then the encryption wait, then 4 reads.
- Ciphertext words are buffered in a small output FIFO and presented on a 32-bit output stream.
- It removes the need for the soft processor to sequence the core word by word.

Parameters:
- COMPUTE_CYCLES, 64: cycles to wait after the last key write before the first read is issued. Must be at least the core's worst-case encrypt time (12 rounds x 5 states plus margin).
- TIMEOUT, 255: maximum consecutive cycles any single master transfer may be held by c_waitrequest before abort.
- OUT_DEPTH, 4: output FIFO depth in 32-bit words. Power of two, at least 4.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  feeder can accept an input word.
- in_data  in  32  input word. Order: text[31:0], text[63:32], text[95:64], text[127:96], key[31:0], key[63:32], key[95:64], key[127:96].
- c_address  out  1  to core address; 1 only on the final key write.
- c_write  out  1  to core write.
- c_writedata  out  32  to core writedata.
- c_read  out  1  to core read.
- c_readdata  in  32  from core readdata.
- c_waitrequest  in  1  from core waitrequest.
- out_valid  out  1  output word valid (output FIFO not empty).
- out_ready  in  1  downstream accepts the output word.
- out_data  out  32  ciphertext word, least-significant word first.
- out_last  out  1  high with the 4th word of each block.
- busy  out  1  high in any state other than IDLE/COLLECT.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async): state=IDLE; word index=0; wait/timeout counters=0; FIFO empty. All outputs 0, including in_ready, c_*, out_valid, err.
- Handshakes:
  - An input word transfers when in_valid and in_ready are both high in a cycle.
  - An output word transfers when out_valid and out_ready are both high.
  - A master transfer completes in a cycle where c_write or c_read is high and c_waitrequest is low.
  - While c_waitrequest is high, the feeder holds c_address, c_writedata, c_write and c_read stable.
  - Read data is sampled in the completing cycle (zero read latency).
- States:
  - IDLE: in_ready=1. Go to COLLECT on the first accepted word, storing it as buffer word 0.
  - COLLECT: in_ready=1 until 8 words are held. On the 8th accepted word, go to WR with idx=0. in_ready is registered and drops the cycle after the 8th accept.
  - WR: c_write=1, c_writedata=buf[idx], c_address=(idx==7). idx increments on each completion; after idx 7 completes, go to WAIT with the counter cleared.
  - WAIT: no bus activity. Counter increments every cycle. When it reaches COMPUTE_CYCLES-1, go to RD with idx=0.
  - RD: c_read=1 only when the FIFO has free space. On completion, push c_readdata with last=(idx==3) and increment idx. After idx 3 completes, go to IDLE.
- The next block may be collected while the FIFO drains; ciphertext order is preserved.
- The FIFO is full when it holds OUT_DEPTH words. RD deasserts c_read while full; this is not a stall and does not count toward timeout.
- Timeout:
  - The counter counts consecutive cycles with a command asserted and c_waitrequest high, and clears on each completion.
  - When it reaches TIMEOUT: set err=1, drop c_write and c_read, discard the buffered block and the partial reads already pushed for it, and go to IDLE.
  - The FIFO keeps all earlier complete blocks.
- Simultaneous FIFO push and pop in one cycle: the count is unchanged and both proceed.
- Input words offered while in_ready=0 are not consumed.
- Reset mid-operation: immediate return to the reset values. The core must be reset by the same reset.

Test Plan:
- Single block: feed text words 0x11111111, 0x22222222, 0x33333333, 0x44444444, then key 0xA0A0A0A0, 0xB0B0B0B0, 0xC0C0C0C0, 0xD0D0D0D0 with out_ready=1.
  - Required: 8 core writes in order, with c_address=1 only on the 0xD0D0D0D0 write.
  - Then 64 idle cycles, then 4 reads.
  - out_data equals the core's 4 readdata words in order, with out_last on the 4th only.
- Write stall: hold c_waitrequest=1 for 5 cycles during write idx 3.
  - Required: c_writedata stays 0x44444444 for all 6 cycles, and idx 4 starts only after completion.
- Backpressure: OUT_DEPTH=4, out_ready=0 through two blocks.
  - Required: the second block's RD issues no c_read while 4 words are queued.
  - When out_ready=1: 8 words drain in order, with out_last on words 4 and 8.
- Timeout: c_waitrequest stuck at 1 during the first read with TIMEOUT=255.
  - Required: err=1 after 255 stalled cycles, then c_read=0, state IDLE, in_ready=1, and no words pushed for that block.
- Reset mid-WAIT: assert reset asynchronously (not on a clock edge).
  - Required: all outputs 0 immediately, out_valid=0, and err=0.
- Back-to-back: feed 16 words with in_valid held high.
  - Required: in_ready drops after word 8 and returns in IDLE.
  - Both blocks produce 8 ordered output words.

Source files
------------

// File: rtl/cipher_stream_feeder.sv
// rtl/cipher_stream_feeder.sv - sequences the 128-bit encrypt core from a 32-bit word stream
// Collects text+key, issues 8 core writes, waits, reads 4 ciphertext words into an output FIFO.
module cipher_stream_feeder #(
   parameter int COMPUTE_CYCLES = 64,
   parameter int TIMEOUT        = 255,
   parameter int OUT_DEPTH      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        c_address,
   output logic        c_write,
   output logic [31:0] c_writedata,
   output logic        c_read,
   input  logic [31:0] c_readdata,
   input  logic        c_waitrequest,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        busy,
   output logic        err
);

   localparam int PW  = $clog2(OUT_DEPTH);
   localparam int WCW = $clog2(COMPUTE_CYCLES + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(COMPUTE_CYCLES - 1);
   localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT - 1);
   localparam logic [PW:0]    DEPTH_C   = (PW+1)'(OUT_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WR, S_WAIT, S_RD} state_t;

   state_t          state_q;
   logic [31:0]     blk_q [8];
   logic [2:0]      idx_q;
   logic [WCW-1:0]  wcnt_q;
   logic [TCW-1:0]  tcnt_q;
   logic            in_ready_q;
   logic            c_write_q;
   logic            c_read_q;
   logic            c_address_q;
   logic [31:0]     c_wdata_q;
   logic            err_q;

   logic [32:0]     mem_q [OUT_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     cnt_q, cnt_d;
   logic [PW:0]     vis_q, vis_d;

   logic            accept, stalled, timeout_hit, wr_done, rd_done;
   logic            push, push_last, pop;
   logic [PW:0]     drop;

   assign accept      = in_valid && in_ready_q;
   assign stalled     = (c_write_q || c_read_q) && c_waitrequest;
   assign timeout_hit = stalled && (tcnt_q == TO_LAST);
   assign wr_done     = c_write_q && !c_waitrequest;
   assign rd_done     = c_read_q && !c_waitrequest;
   assign push        = rd_done;
   assign push_last   = (idx_q == 3'd3);
   assign pop         = out_valid && out_ready;
   // Words of a block only become visible once its last word lands, so an abort can rewind them.
   assign drop        = (timeout_hit && state_q == S_RD) ? (PW+1)'(idx_q) : '0;

   always_comb begin
      cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop) - drop;
      vis_d    = vis_q - (PW+1)'(pop);
      if (push && push_last) begin
         vis_d = cnt_q + (PW+1)'(1) - (PW+1)'(pop);
      end
      wr_ptr_d = wr_ptr_q + PW'(push) - drop[PW-1:0];
      rd_ptr_d = rd_ptr_q + PW'(pop);
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         blk_q[idx_q] <= in_data;
      end
      if (push) begin
         mem_q[wr_ptr_q] <= {push_last, c_readdata};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         vis_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         vis_q    <= vis_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         wcnt_q      <= '0;
         tcnt_q      <= '0;
         in_ready_q  <= 1'b0;
         c_write_q   <= 1'b0;
         c_read_q    <= 1'b0;
         c_address_q <= 1'b0;
         c_wdata_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         if (wr_done || rd_done || timeout_hit) begin
            tcnt_q <= '0;
         end else if (stalled) begin
            tcnt_q <= tcnt_q + TCW'(1);
         end

         case (state_q)
            S_IDLE: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  idx_q   <= 3'd1;
                  state_q <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (accept) begin
                  if (idx_q == 3'd7) begin
                     in_ready_q  <= 1'b0;
                     idx_q       <= '0;
                     c_write_q   <= 1'b1;
                     c_wdata_q   <= blk_q[0];
                     c_address_q <= 1'b0;
                     state_q     <= S_WR;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            S_WR: begin
               if (timeout_hit) begin
                  err_q       <= 1'b1;
                  c_write_q   <= 1'b0;
                  c_address_q <= 1'b0;
                  idx_q       <= '0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end else if (wr_done) begin
                  if (idx_q == 3'd7) begin
                     c_write_q   <= 1'b0;
                     c_address_q <= 1'b0;
                     wcnt_q      <= '0;
                     state_q     <= S_WAIT;
                  end else begin
                     idx_q       <= idx_q + 3'd1;
                     c_wdata_q   <= blk_q[idx_q + 3'd1];
                     c_address_q <= (idx_q == 3'd6);
                  end
               end
            end
            S_WAIT: begin
               wcnt_q <= wcnt_q + WCW'(1);
               if (wcnt_q == WAIT_LAST) begin
                  idx_q    <= '0;
                  c_read_q <= (cnt_q < DEPTH_C);
                  state_q  <= S_RD;
               end
            end
            S_RD: begin
               if (timeout_hit) begin
                  err_q      <= 1'b1;
                  c_read_q   <= 1'b0;
                  idx_q      <= '0;
                  in_ready_q <= 1'b1;
                  state_q    <= S_IDLE;
               end else if (rd_done) begin
                  if (idx_q == 3'd3) begin
                     c_read_q   <= 1'b0;
                     idx_q      <= '0;
                     in_ready_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     idx_q    <= idx_q + 3'd1;
                     c_read_q <= ((cnt_q + (PW+1)'(1)) < DEPTH_C);
                  end
               end else if (!c_read_q) begin
                  // A full FIFO parks the read request without starting the timeout count.
                  c_read_q <= (cnt_q < DEPTH_C);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign c_address   = c_address_q;
   assign c_write     = c_write_q;
   assign c_writedata = c_wdata_q;
   assign c_read      = c_read_q;
   assign out_valid   = (vis_q != '0);
   assign out_data    = out_valid ? mem_q[rd_ptr_q][31:0] : '0;
   assign out_last    = out_valid ? mem_q[rd_ptr_q][32] : 1'b0;
   assign busy        = (state_q == S_WR) || (state_q == S_WAIT) || (state_q == S_RD);
   assign err         = err_q;

endmodule

// File: tb/tb_cipher_stream_feeder.sv
// tb/tb_cipher_stream_feeder.sv - scoreboard bench for cipher_stream_feeder with a behavioural core
module tb_cipher_stream_feeder;

   localparam logic [31:0] CK = 32'hC3C3_0F0F;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        c_address, c_write, c_read;
   logic [31:0] c_writedata;
   logic [31:0] c_readdata;
   logic        c_waitrequest = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy, err;

   always #5 clk = ~clk;

   cipher_stream_feeder #(.COMPUTE_CYCLES(64), .TIMEOUT(255), .OUT_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .c_address(c_address), .c_write(c_write), .c_writedata(c_writedata),
      .c_read(c_read), .c_readdata(c_readdata), .c_waitrequest(c_waitrequest),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .err(err)
   );

   typedef struct packed {
      logic [7:0][31:0] w;
      logic [3:0][31:0] e;
      logic             rmode;
   } vec_t;

   vec_t        vecs [4];
   logic [31:0] exp_wr [$];
   logic [32:0] exp_out [$];

   int errors = 0;
   int checks = 0;

   // core model and monitor state
   logic [31:0] core_mem [8];
   int  core_wr_n = 0, core_rd_n = 0;
   bit  rd_pend = 0;
   int  rd_total = 0, wr_total = 0, pops = 0;
   int  gap = 0;
   bit  gap_run = 0;
   bit  gap_exact = 1;
   int  stall_mode = 0;
   int  stall_cnt = 0, wr3_cycles = 0, stall_rd = 0;

   assign c_readdata = core_mem[core_rd_n % 4] ^ core_mem[(core_rd_n % 4) + 4] ^ CK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic        w;
      logic [32:0] e;
      if (reset) begin
         c_waitrequest = 1'b0;
         core_wr_n = 0; core_rd_n = 0; rd_pend = 0;
         rd_total = 0; pops = 0; gap_run = 0;
      end else begin
         if (rd_pend) begin core_rd_n++; rd_pend = 0; end
         if (stall_mode != 1) begin stall_cnt = 0; wr3_cycles = 0; end
         if (stall_mode != 2) stall_rd = 0;
         w = 1'b0;
         if (stall_mode == 1 && c_write && core_wr_n == 3) begin
            wr3_cycles++;
            chk("stall_wdata", c_writedata, 32'h4444_4444);
            if (stall_cnt < 5) begin w = 1'b1; stall_cnt++; end
         end
         if (stall_mode == 2 && c_read) begin w = 1'b1; stall_rd++; end
         c_waitrequest = w;

         if (c_write && !w) begin
            chk("wr_addr", c_address, core_wr_n == 7);
            if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("wr_data", c_writedata, exp_wr.pop_front());
            core_mem[core_wr_n] = c_writedata;
            wr_total++;
            core_wr_n = (core_wr_n + 1) % 8;
            if (core_wr_n == 0) begin core_rd_n = 0; gap = 0; gap_run = 1; end
         end else if (gap_run && !c_write && !c_read) begin
            gap++;
         end

         if (c_read) begin
            if (gap_run) begin
               if (gap_exact) chk("wait_gap", gap, 64);
               gap_run = 0;
            end
            chk("rd_space", (rd_total - pops) < 4, 1);
            if (!w) begin rd_pend = 1; rd_total++; end
         end

         if (out_valid && out_ready) begin
            pops++;
            if (exp_out.size() == 0) chk("out_unexpected", 1, 0);
            else begin
               e = exp_out.pop_front();
               chk("out_data", out_data, e[31:0]);
               chk("out_last", out_last, e[32]);
            end
         end
      end
   end

   task automatic feed_word(input logic [31:0] wd);
      int n = 0;
      in_valid = 1'b1;
      in_data  = wd;
      while (!in_ready && n < 2000) begin @(posedge clk); #1; n++; end
      if (!in_ready) chk("feed_timeout", 0, 1);
      else begin @(posedge clk); #1; end
   endtask

   task automatic feed_block(input vec_t v, input bit keep);
      for (int i = 0; i < 4; i++) exp_out.push_back({i == 3, v.e[i]});
      for (int i = 0; i < 8; i++) begin
         exp_wr.push_back(v.w[i]);
         feed_word(v.w[i]);
      end
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain(input bit rmode);
      int n = 0;
      while (exp_out.size() != 0 && n < 3000) begin
         out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1; n++;
      end
      out_ready = 1'b1;
      chk("drain", exp_out.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, r0, w0;
      for (int v = 0; v < 4; v++) vecs[v] = '0;
      vecs[0].w[0] = 32'h1111_1111; vecs[0].w[1] = 32'h2222_2222;
      vecs[0].w[2] = 32'h3333_3333; vecs[0].w[3] = 32'h4444_4444;
      vecs[0].w[4] = 32'hA0A0_A0A0; vecs[0].w[5] = 32'hB0B0_B0B0;
      vecs[0].w[6] = 32'hC0C0_C0C0; vecs[0].w[7] = 32'hD0D0_D0D0;
      for (int i = 0; i < 8; i++) begin
         vecs[1].w[i] = (i < 4) ? 32'h0 : 32'hFFFF_FFFF;
         vecs[2].w[i] = (i < 4) ? (32'h1 << (i * 8)) : (32'h8000_0000 >> i);
         vecs[3].w[i] = $urandom;
      end
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < 4; i++) vecs[v].e[i] = vecs[v].w[i] ^ vecs[v].w[i + 4] ^ CK;
         vecs[v].rmode = v[0];
      end

      // reset state
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cmd", {c_write, c_read, c_address}, 0);
      chk("rst_wdata", c_writedata, 0);
      chk("rst_out", {out_valid, out_last, out_data}, 0);
      chk("rst_busy_err", {busy, err}, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_ready", in_ready, 1);

      // table-driven blocks
      for (int v = 0; v < 4; v++) begin
         gap_exact = 1;
         feed_block(vecs[v], 0);
         drain(vecs[v].rmode);
         chk("idle_after_block", busy, 0);
         chk("err_clear", err, 0);
      end

      // write stall on idx 3
      stall_mode = 1;
      feed_block(vecs[0], 0);
      drain(0);
      chk("stall_cycles", wr3_cycles, 6);
      chk("stall_count", stall_cnt, 5);
      stall_mode = 0;

      // backpressure through two blocks
      gap_exact = 0;
      out_ready = 1'b0;
      r0 = rd_total;
      feed_block(vecs[1], 0);
      n = 0;
      while (rd_total - r0 < 4 && n < 2000) begin @(posedge clk); #1; n++; end
      chk("bp_first_reads", rd_total - r0, 4);
      w0 = wr_total;
      feed_block(vecs[2], 0);
      n = 0;
      while (wr_total - w0 < 8 && n < 2000) begin @(posedge clk); #1; n++; end
      repeat (150) @(posedge clk);
      #1;
      chk("bp_no_read", rd_total - r0, 4);
      chk("bp_busy", busy, 1);
      chk("bp_valid", out_valid, 1);
      drain(0);
      chk("bp_all_reads", rd_total - r0, 8);
      gap_exact = 1;

      // back-to-back with in_valid held high
      feed_block(vecs[3], 1);
      chk("b2b_ready_drop", in_ready, 0);
      n = 0;
      while (!in_ready && n < 2000) begin @(posedge clk); #1; n++; end
      chk("b2b_ready_back", in_ready, 1);
      chk("b2b_idle", busy, 0);
      feed_block(vecs[2], 0);
      drain(0);

      // read timeout
      stall_mode = 2;
      feed_block(vecs[0], 0);
      n = 0;
      while (!err && n < 2000) begin @(posedge clk); #1; n++; end
      chk("to_err", err, 1);
      chk("to_stall_len", stall_rd, 255);
      chk("to_read_low", c_read, 0);
      chk("to_idle", {busy, in_ready}, 2'b01);
      chk("to_no_push", out_valid, 0);
      stall_mode = 0;
      repeat (4) void'(exp_out.pop_back());
      repeat (5) @(posedge clk);
      #1;
      chk("to_no_push_later", out_valid, 0);
      feed_block(vecs[1], 0);
      drain(0);
      chk("err_sticky", err, 1);

      // asynchronous reset in WAIT
      w0 = wr_total;
      feed_block(vecs[2], 0);
      n = 0;
      while (wr_total - w0 < 8 && n < 2000) begin @(posedge clk); #1; n++; end
      repeat (10) @(posedge clk);
      #1;
      chk("pre_rst_wait", {busy, c_write, c_read}, 3'b100);
      chk("pre_rst_err", err, 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_cmd", {c_write, c_read, c_address, c_writedata}, 0);
      chk("mid_rst_state", {in_ready, busy, err}, 0);
      chk("mid_rst_out", {out_valid, out_last, out_data}, 0);
      exp_out.delete();
      exp_wr.delete();
      @(posedge clk); #1 reset = 1'b0;
      feed_block(vecs[3], 0);
      drain(1);
      chk("post_rst_err", err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
